// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin select arbiter.
// Imported by the picker and the arbiter top.
package rr_sel_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// at or above ptr, wrapping from the top index back to 0.
module rr_pick
  import rr_sel_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter with bounded hold time and a one-cycle gap
// between grants; all outputs are registered.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic             sel_en,
  output logic             busy
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;
  logic             armed;
  logic             found;
  logic [IDX_W-1:0] idx;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  // armed blocks arbitration on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      sel_en   <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE, GAP: begin
          if (found && (armed || state == GAP)) begin
            state    <= GRANT;
            gnt      <= N_REQ'(1) << idx;
            sel      <= idx;
            sel_en   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel] || hold_cnt == HOLD_LAST) begin
            state    <= GAP;
            gnt      <= '0;
            sel_en   <= 1'b0;
            ptr      <= sel + 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          sel_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus randomized
// request traffic against a cycle-level ownership model.
module tb_rr_sel_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       sel_en;
  logic       busy;

  rr_sel_arbiter #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .sel    (sel),
    .sel_en (sel_en),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int owner;
  bit in_gap;
  int held;
  int start;
  int last_sel;
  bit armed;

  function automatic int first_from(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  // Ownership model: who holds the resource and for how long.
  always @(posedge clk or negedge rst_n) begin : mdl
    int f;
    if (!rst_n) begin
      owner = -1; in_gap = 0; held = 0;
      start = 0; last_sel = 0; armed = 0;
    end else begin
      if (owner >= 0) begin
        held++;
        if (!req[owner] || held == MH) begin
          start  = (owner + 1) % 8;
          owner  = -1;
          in_gap = 1;
        end
      end else begin
        f = first_from(req, start);
        if (f >= 0 && (armed || in_gap)) begin
          owner    = f;
          last_sel = f;
          held     = 0;
        end
        in_gap = 0;
      end
      armed = 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    logic       ee, eb;
    if (cmp_on) begin
      eg = (owner >= 0) ? (8'd1 << owner) : 8'd0;
      ee = (owner >= 0);
      eb = (owner >= 0) || in_gap;
      checks++;
      if (gnt !== eg || sel !== 3'(last_sel) || sel_en !== ee || busy !== eb) begin
        errors++;
        $display("FAIL model t=%0t got gnt=%h sel=%0d en=%b busy=%b exp gnt=%h sel=%0d en=%b busy=%b",
                 $time, gnt, sel, sel_en, busy, eg, last_sel, ee, eb);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 8'h00;
    #1 rst_n = 1'b0;
    #1 cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    req   = 8'h04;
    @(negedge clk);
    chk("arm_gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("g_gnt", 32'(gnt), 32'h04);
    chk("g_sel", 32'(sel), 2);
    chk("g_en", 32'(sel_en), 1);
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt), 0);
    chk("drop_busy", 32'(busy), 1);
    chk("drop_sel", 32'(sel), 2);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    req = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rr_en", 32'(sel_en), (c % 5 != 4) ? 1 : 0);
      chk("rr_sel", 32'(sel), (c < 5) ? 3 : 4);
    end
    req = 8'h00;
    @(negedge clk);
    chk("rr_idle", 32'(busy), 0);

    req = 8'h20;
    @(negedge clk);
    chk("w5_sel", 32'(sel), 5);
    req = 8'h03;
    @(negedge clk);
    chk("w_gap_en", 32'(sel_en), 0);
    chk("w_gap_sel", 32'(sel), 5);
    @(negedge clk);
    chk("w0_sel", 32'(sel), 0);
    chk("w0_en", 32'(sel_en), 1);
    repeat (5) @(negedge clk);
    chk("w1_sel", 32'(sel), 1);
    chk("w1_en", 32'(sel_en), 1);
    req = 8'h00;
    repeat (2) @(negedge clk);

    req = 8'h08;
    @(negedge clk);
    chk("s3_sel", 32'(sel), 3);
    repeat (3) @(negedge clk);
    chk("s3_last", 32'(gnt), 32'h08);
    req = 8'h00;
    @(negedge clk);
    chk("s_gap_en", 32'(sel_en), 0);
    chk("s_gap_busy", 32'(busy), 1);
    req = 8'hFF;
    @(negedge clk);
    chk("s_next_sel", 32'(sel), 4);
    chk("s_next_en", 32'(sel_en), 1);
    req = 8'h00;
    repeat (3) @(negedge clk);

    req = 8'h08;
    @(negedge clk);
    chk("r3_sel", 32'(sel), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_en", 32'(sel_en), 0);
    chk("ar_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_arm", 32'(gnt), 0);
    @(negedge clk);
    chk("ar_regnt", 32'(gnt), 32'h08);
    chk("ar_sel", 32'(sel), 3);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 60) == 0) req = 8'h00;
      if ($urandom_range(0, 400) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one requester keeps a grant (legal range 2..256).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  per-requester request level; held high while the requester wants the shared resource.
REQ-005 Port: gnt  output  8  one-hot registered grant; all-zero when no grant.
REQ-006 Port: sel  output  3  binary index of granted requester, driving the 3-to-8 select input of the shared resource.
REQ-007 Port: sel_en  output  1  high exactly when gnt is non-zero, driving the select-enable input of the shared resource.
REQ-008 Port: busy  output  1  high in GRANT and GAP states.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-010 IDLE: when req != 0 at a rising edge, SHALL enter GRANT with gnt/sel set to the first asserted req index searching upward from ptr, wrapping 7->0; otherwise SHALL stay in IDLE.
REQ-011 Grant latency SHALL be one cycle: gnt is visible in the cycle after the edge that samples req.
REQ-012 GRANT: hold_cnt SHALL increment by 1 per cycle starting from 0 on grant entry; gnt, sel and sel_en SHALL stay constant.
REQ-013 GRANT SHALL exit to GAP when req[sel] is low or hold_cnt == MAX_HOLD-1, whichever comes first; a simultaneous drop and timeout SHALL be treated as a single exit.
REQ-014 On the GRANT->GAP edge: gnt SHALL become 0, sel_en 0, ptr SHALL become sel+1 modulo 8, and hold_cnt SHALL become 0.
REQ-015 sel SHALL retain its last value while sel_en is 0.
REQ-016 GAP SHALL last exactly one cycle with no grant, then arbitrate as in REQ-010 using the updated ptr; if req == 0, SHALL go to IDLE.
REQ-017 A timed-out requester that still holds req high SHALL be granted again only after every other asserted requester has been searched, i.e. when it is the first asserted index from ptr.
REQ-018 req changes during GAP SHALL be sampled only at the GAP exit edge; no grant SHALL be issued inside GAP.
REQ-019 hold_cnt width SHALL be ceil(log2(MAX_HOLD)) bits and SHALL never exceed MAX_HOLD-1.
REQ-020 gnt SHALL always equal the one-hot decode of sel when sel_en is 1, and SHALL be zero otherwise.

Reset
REQ-021 While rst_n is low, the block SHALL hold: state IDLE, gnt 0, sel 0, sel_en 0, busy 0, ptr 0, hold_cnt 0.
REQ-022 Reset assertion mid-GRANT SHALL drop gnt and sel_en immediately (asynchronously).
REQ-023 After rst_n deasserts, the first possible grant SHALL be at the second rising edge.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, GRANT, GAP), the requester count constant N_REQ = 8, and the index width constant IDX_W = 3.
REQ-025 One sub-module, rr_pick, SHALL be combinational: inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0], the first asserted index at or above ptr with wrap-around.
REQ-026 All outputs SHALL be driven directly from registers.

Verification
REQ-027 Single request: req=8'h04 from cycle 0 -> gnt=8'h04, sel=2, sel_en=1 from cycle 1; req drops at cycle 5 -> gnt=0 at cycle 6, IDLE at cycle 7.
REQ-028 Round-robin: req=8'hFF held constant, MAX_HOLD=4 -> grant order 0,1,2,...,7,0; each grant lasts 4 cycles followed by one GAP cycle.
REQ-029 Wrap: ptr=6 after a grant to 5, req=8'h03 -> grant to index 0, then to 1.
REQ-030 Timeout with a sole requester: req=8'h10 held constant, MAX_HOLD=16 -> gnt=8'h10 for 16 cycles, 1 zero cycle, then regranted to index 4.
REQ-031 Reset mid-grant: rst_n low during GRANT for index 3 -> gnt=0 and sel_en=0 with no clock edge; after release with req=8'h08 -> grant to index 3 (ptr=0 searches upward).
REQ-032 Simultaneous drop and timeout on the same cycle -> exactly one GAP cycle and ptr advanced by one.
